// File: rtl/riscfw_pkg.sv
// Shared definitions for the writeback path: default data width and
// register-address type used by the arbiter and its scoreboard.
package riscfw_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int NUM_REGS = 32;

    typedef logic [4:0] reg_addr_t;

    // Register x0 is hardwired to zero and can never be pending.
    localparam logic [NUM_REGS-1:0] X0_CLEAR_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    function automatic logic [NUM_REGS-1:0] reg_bit(input reg_addr_t addr);
        reg_bit = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
    endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// Register scoreboard: one pending bit per register, set on issue, cleared on
// writeback (set wins on collision), and a combinational hazard query.
module wb_scoreboard
    import riscfw_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    input  reg_addr_t           rs1_addr,
    input  reg_addr_t           rs2_addr,
    input  logic                rs1_bypass,
    input  logic                rs2_bypass,
    output logic [NUM_REGS-1:0] pending,
    output logic                stall
);
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                rs1_busy;
    logic                rs2_busy;

    assign set_mask = set_en ? reg_bit(set_addr) : '0;
    assign clr_mask = clr_en ? reg_bit(clr_addr) : '0;

    // Applying the set after the clear lets a new issue win over a retiring write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & X0_CLEAR_MASK;
        end
    end

    assign rs1_busy = (rs1_addr != '0) && pending[rs1_addr] && !rs1_bypass;
    assign rs2_busy = (rs2_addr != '0) && pending[rs2_addr] && !rs2_bypass;
    assign stall    = rs1_busy || rs2_busy;
endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges load and ALU results into one registered
// register-file write port and tracks in-flight destinations.
// Optional operand forwarding from the write port: define WB_FORWARD_EN.
module writeback_arbiter
    import riscfw_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  reg_addr_t           issue_rd,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  reg_addr_t           alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  reg_addr_t           mem_rd,
    input  logic [XLEN-1:0]     mem_data,
    output logic                write_enable,
    output reg_addr_t           write_addr,
    output logic [XLEN-1:0]     write_data,
    input  reg_addr_t           rs1_addr,
    input  reg_addr_t           rs2_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending
`ifdef WB_FORWARD_EN
    ,
    output logic                fwd1_hit,
    output logic                fwd2_hit,
    output logic [XLEN-1:0]     fwd_data
`endif
);
    logic            mem_fire;
    logic            alu_fire;
    logic            acc_valid;
    reg_addr_t       acc_rd;
    logic [XLEN-1:0] acc_data;
    logic            rs1_bypass;
    logic            rs2_bypass;

    // Loads always win; the ALU waits whenever a load result is presented.
    assign mem_ready = 1'b1;
    assign alu_ready = !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        acc_valid = mem_fire || alu_fire;
        acc_rd    = alu_rd;
        acc_data  = alu_data;
        if (mem_fire) begin
            acc_rd   = mem_rd;
            acc_data = mem_data;
        end
    end

    // Results to x0 are consumed but never written, and the port keeps its old address/data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= acc_valid && (acc_rd != '0);
            if (acc_valid && (acc_rd != '0)) begin
                write_addr <= acc_rd;
                write_data <= acc_data;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd1_hit   = write_enable && (rs1_addr != '0) && (write_addr == rs1_addr);
    assign fwd2_hit   = write_enable && (rs2_addr != '0) && (write_addr == rs2_addr);
    assign fwd_data   = write_data;
    assign rs1_bypass = fwd1_hit;
    assign rs2_bypass = fwd2_hit;
`else
    assign rs1_bypass = 1'b0;
    assign rs2_bypass = 1'b0;
`endif

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en     (issue_valid),
        .set_addr   (issue_rd),
        .clr_en     (write_enable),
        .clr_addr   (write_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_bypass (rs1_bypass),
        .rs2_bypass (rs2_bypass),
        .pending    (pending),
        .stall      (stall)
    );
endmodule
